// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit feeding the MEM/WB register.
// Runs a single request/acknowledge bus transaction per load or store.
// Store data is replicated across the byte lanes, and load results are
// sign- or zero-extended. The pipeline is held on StallM until the access
// completes.
// Optional feature: define LSU_TIMEOUT_EN to abort a request that waits
// TIMEOUT_CYCLES REQ cycles without a BusAck.
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] AddrM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        AccessFaultM,
    output logic        BusReq,
    output logic        BusWe,
    output logic [31:0] BusAddr,
    output logic [3:0]  BusByteEn,
    output logic [31:0] BusWData,
    input  logic        BusAck,
    input  logic        BusErr,
    input  logic [31:0] BusRData
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // The timeout counter must be able to hold TIMEOUT_CYCLES.
    if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_cnt_w_check
        $error("mem_stage_lsu: CNT_W too narrow for TIMEOUT_CYCLES");
    end

    state_t      r_state;
    state_t      w_next;

    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_rdata;
    logic        r_misalign;
    logic        r_fault;
    logic [2:0]  r_f3;
    logic [1:0]  r_a;

    logic        w_access;
    logic        w_f3_ok;
    logic        w_fault_req;
    logic        w_misalign;
    logic        w_start;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    // Pick the addressed byte/half out of the word and extend it to 32 bits.
    function automatic logic [31:0] f_load_ext(input logic [2:0]  f3,
                                               input logic [1:0]  a,
                                               input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> {a, 3'b000};
        case (f3)
            3'b000:  f_load_ext = {{24{sh[7]}}, sh[7:0]};
            3'b001:  f_load_ext = {{16{sh[15]}}, sh[15:0]};
            3'b100:  f_load_ext = {24'b0, sh[7:0]};
            3'b101:  f_load_ext = {16'b0, sh[15:0]};
            default: f_load_ext = rdata;
        endcase
    endfunction

    // Decode whether funct3 names a real RV32I load or store.
    always_comb begin
        w_f3_ok = 1'b0;
        if (MemReadM) begin
            case (Funct3M)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_ok = 1'b1;
                default:                                w_f3_ok = 1'b0;
            endcase
        end else begin
            case (Funct3M)
                3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
                default:                w_f3_ok = 1'b0;
            endcase
        end
    end

    // Faults take priority over misalignment so the two flags never coincide.
    assign w_access    = MemReadM | MemWriteM;
    assign w_fault_req = w_access & ((MemReadM & MemWriteM) | ~w_f3_ok);
    assign w_misalign  = w_access & ~w_fault_req &
                         (((Funct3M[1:0] == 2'b01) & AddrM[0]) |
                          ((Funct3M[1:0] == 2'b10) & (AddrM[1:0] != 2'b00)));
    assign w_start     = (r_state == S_IDLE) & w_access & ~w_fault_req & ~w_misalign;

    // Store byte-lane enables and replicated write data; loads enable all lanes.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = WriteDataM;
        if (MemWriteM) begin
            case (Funct3M[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << AddrM[1:0];
                    w_wdata = {4{WriteDataM[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << AddrM[1:0];
                    w_wdata = {2{WriteDataM[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = WriteDataM;
                end
            endcase
        end
    end

`ifdef LSU_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;

    // Count REQ cycles that pass without an acknowledge.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_cnt <= '0;
        end else if (w_start) begin
            r_cnt <= '0;
        end else if ((r_state == S_REQ) && !BusAck) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_REQ) && !BusAck &&
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and the combinational pipeline stall.
    always_comb begin
        w_next = r_state;
        StallM = 1'b0;
        case (r_state)
            S_IDLE: begin
                StallM = w_start;
                if (w_start) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                StallM = 1'b1;
                if (BusAck || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Bus outputs, load result and one-cycle status flags.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
            r_rdata     <= '0;
            r_misalign  <= 1'b0;
            r_fault     <= 1'b0;
            r_f3        <= '0;
            r_a         <= '0;
        end else begin
            r_misalign <= 1'b0;
            r_fault    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fault_req) begin
                        r_fault <= 1'b1;
                    end else if (w_misalign) begin
                        r_misalign <= 1'b1;
                        r_rdata    <= '0;
                    end else if (w_start) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= MemWriteM;
                        r_bus_addr  <= {AddrM[31:2], 2'b00};
                        r_bus_be    <= w_be;
                        r_bus_wdata <= w_wdata;
                        r_f3        <= Funct3M;
                        r_a         <= AddrM[1:0];
                    end
                end
                S_REQ: begin
                    if (BusAck) begin
                        r_bus_req <= 1'b0;
                        if (BusErr) begin
                            r_rdata <= '0;
                            r_fault <= 1'b1;
                        end else if (!r_bus_we) begin
                            r_rdata <= f_load_ext(r_f3, r_a, BusRData);
                        end
                    end else if (w_timeout) begin
                        r_bus_req <= 1'b0;
                        r_rdata   <= '0;
                        r_fault   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ReadDataM    = r_rdata;
    assign MisalignM    = r_misalign;
    assign AccessFaultM = r_fault;
    assign BusReq       = r_bus_req;
    assign BusWe        = r_bus_we;
    assign BusAddr      = r_bus_addr;
    assign BusByteEn    = r_bus_be;
    assign BusWData     = r_bus_wdata;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Testbench for mem_stage_lsu: fixed vector table, hand-written corner
// sequences and randomized accesses against a byte-level reference model.
module tb_mem_stage_lsu;

    localparam int TB_TIMEOUT = 4;
    localparam int K_BUS   = 0;
    localparam int K_FAULT = 1;
    localparam int K_MIS   = 2;

    logic        CLK;
    logic        RESETn;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] AddrM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MisalignM;
    logic        AccessFaultM;
    logic        BusReq;
    logic        BusWe;
    logic [31:0] BusAddr;
    logic [3:0]  BusByteEn;
    logic [31:0] BusWData;
    logic        BusAck;
    logic        BusErr;
    logic [31:0] BusRData;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] brdata;
        logic        err;
        int          waits;
        int          kind;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        fault;
    } vec_t;

    mem_stage_lsu #(
        .TIMEOUT_CYCLES(TB_TIMEOUT),
        .CNT_W(8)
    ) dut (
        .CLK(CLK),
        .RESETn(RESETn),
        .MemReadM(MemReadM),
        .MemWriteM(MemWriteM),
        .Funct3M(Funct3M),
        .AddrM(AddrM),
        .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM),
        .StallM(StallM),
        .MisalignM(MisalignM),
        .AccessFaultM(AccessFaultM),
        .BusReq(BusReq),
        .BusWe(BusWe),
        .BusAddr(BusAddr),
        .BusByteEn(BusByteEn),
        .BusWData(BusWData),
        .BusAck(BusAck),
        .BusErr(BusErr),
        .BusRData(BusRData)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        Funct3M    = 3'b000;
        AddrM      = 32'h0;
        WriteDataM = 32'h0;
    endtask

    function automatic vec_t mk(logic rd, logic wr, logic [2:0] f3, logic [31:0] addr,
                                logic [31:0] wd, logic [31:0] brdata, logic err, int waits,
                                int kind, logic [3:0] be, logic [31:0] wdata,
                                logic [31:0] exp_rd, logic fault);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd; v.brdata = brdata;
        v.err = err; v.waits = waits; v.kind = kind; v.be = be; v.wdata = wdata;
        v.exp_rd = exp_rd; v.fault = fault;
        return v;
    endfunction

    // Reference model: access size/sign from funct3, then byte-by-byte lanes.
    function automatic vec_t model(logic rd, logic wr, logic [2:0] f3, logic [31:0] addr,
                                   logic [31:0] wd, logic [31:0] brdata, logic err,
                                   int waits, logic [31:0] prev);
        vec_t r;
        int size;
        bit sgn;
        int off;
        logic [31:0] val;
        r = mk(rd, wr, f3, addr, wd, brdata, err, waits, K_BUS, 4'h0, 32'h0, prev, 1'b0);
        size = 0;
        sgn  = 1'b0;
        if (rd && !wr) begin
            case (f3)
                3'd0: begin size = 1; sgn = 1'b1; end
                3'd1: begin size = 2; sgn = 1'b1; end
                3'd2: size = 4;
                3'd4: size = 1;
                3'd5: size = 2;
                default: size = 0;
            endcase
        end else if (wr && !rd) begin
            case (f3)
                3'd0: size = 1;
                3'd1: size = 2;
                3'd2: size = 4;
                default: size = 0;
            endcase
        end
        off = int'(addr[1:0]);
        if (size == 0) begin
            r.kind  = K_FAULT;
            r.fault = 1'b1;
        end else if ((off % size) != 0) begin
            r.kind   = K_MIS;
            r.exp_rd = 32'h0;
        end else if (wr) begin
            for (int i = 0; i < size; i++) r.be[off + i] = 1'b1;
            for (int k = 0; k < 4; k++) r.wdata[8*k +: 8] = wd[8*(k % size) +: 8];
            if (err) begin
                r.exp_rd = 32'h0;
                r.fault  = 1'b1;
            end
        end else begin
            r.be = 4'hF;
            if (err) begin
                r.exp_rd = 32'h0;
                r.fault  = 1'b1;
            end else begin
                val = 32'h0;
                for (int i = 0; i < size; i++) val[8*i +: 8] = brdata[8*(off + i) +: 8];
                if (sgn && val[8*size - 1])
                    for (int i = size; i < 4; i++) val[8*i +: 8] = 8'hFF;
                r.exp_rd = val;
            end
        end
        return r;
    endfunction

    // Drive one M-stage access, act as the bus slave, and check every cycle.
    task automatic run_op(input string nm, input vec_t v);
        int req_cycles;
        int stalls;
        int exp_req;
        bit done;
        @(negedge CLK);
        MemReadM = v.rd; MemWriteM = v.wr; Funct3M = v.f3; AddrM = v.addr; WriteDataM = v.wd;
        BusRData = ~v.brdata;
        #1;
        if (v.kind != K_BUS) begin
            chk({nm, " stall"}, 32'(StallM), 32'd0);
            @(posedge CLK);
            @(negedge CLK);
            idle_inputs();
            #1;
            chk({nm, " fault flag"}, 32'(AccessFaultM), 32'(v.kind == K_FAULT));
            chk({nm, " misalign flag"}, 32'(MisalignM), 32'(v.kind == K_MIS));
            chk({nm, " no busreq"}, 32'(BusReq), 32'd0);
            chk({nm, " readdata"}, ReadDataM, v.exp_rd);
            @(posedge CLK);
            @(negedge CLK);
            #1;
            chk({nm, " flags one cycle"}, 32'({AccessFaultM, MisalignM}), 32'd0);
        end else begin
            exp_req = (v.waits < 0) ? TB_TIMEOUT : v.waits + 1;
            chk({nm, " idle stall"}, 32'(StallM), 32'd1);
            stalls = int'(StallM);
            req_cycles = 0;
            done = 1'b0;
            for (int c = 0; c < 300 && !done; c++) begin
                @(posedge CLK);
                @(negedge CLK);
                BusAck = 1'b0; BusErr = 1'b0; BusRData = ~v.brdata;
                #1;
                if (BusReq === 1'b1) begin
                    req_cycles++;
                    stalls += int'(StallM);
                    chk({nm, " req we"}, 32'(BusWe), 32'(v.wr));
                    chk({nm, " req addr"}, BusAddr, {v.addr[31:2], 2'b00});
                    chk({nm, " req be"}, 32'(BusByteEn), 32'(v.be));
                    if (v.wr) chk({nm, " req wdata"}, BusWData, v.wdata);
                    if (v.waits >= 0 && req_cycles == v.waits + 1) begin
                        BusAck = 1'b1; BusErr = v.err; BusRData = v.brdata;
                    end
                end else begin
                    done = 1'b1;
                end
            end
            chk({nm, " completed"}, 32'(done), 32'd1);
            chk({nm, " req cycles"}, 32'(req_cycles), 32'(exp_req));
            chk({nm, " stall cycles"}, 32'(stalls), 32'(exp_req + 1));
            chk({nm, " done stall"}, 32'(StallM), 32'd0);
            chk({nm, " done fault"}, 32'(AccessFaultM), 32'(v.fault));
            chk({nm, " done misalign"}, 32'(MisalignM), 32'd0);
            chk({nm, " readdata"}, ReadDataM, v.exp_rd);
            @(posedge CLK);
            @(negedge CLK);
            idle_inputs();
            #1;
            chk({nm, " back idle"}, 32'({BusReq, StallM, AccessFaultM}), 32'd0);
        end
    endtask

    vec_t tbl[$];
    vec_t v;
    logic [31:0] model_rd;
    logic        r_rd, r_wr;
    int          sel;

    initial begin
        RESETn = 1'b0;
        BusAck = 1'b0; BusErr = 1'b0; BusRData = 32'h0;
        idle_inputs();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        #1;
        chk("reset busreq", 32'(BusReq), 32'd0);
        chk("reset buswe", 32'(BusWe), 32'd0);
        chk("reset busaddr", BusAddr, 32'h0);
        chk("reset be", 32'(BusByteEn), 32'd0);
        chk("reset wdata", BusWData, 32'h0);
        chk("reset readdata", ReadDataM, 32'h0);
        chk("reset flags", 32'({MisalignM, AccessFaultM, StallM}), 32'd0);
        RESETn = 1'b1;

        tbl.push_back(mk(1, 0, 3'b000, 32'h1003, 32'h0, 32'h80123456, 0, 0, K_BUS, 4'hF, 32'h0, 32'hFFFFFF80, 0));
        tbl.push_back(mk(1, 0, 3'b100, 32'h1003, 32'h0, 32'h80123456, 0, 0, K_BUS, 4'hF, 32'h0, 32'h00000080, 0));
        tbl.push_back(mk(0, 1, 3'b001, 32'h2002, 32'hDEADBEEF, 32'h0, 0, 3, K_BUS, 4'b1100, 32'hBEEFBEEF, 32'h00000080, 0));
        tbl.push_back(mk(1, 0, 3'b010, 32'h3001, 32'h0, 32'h0, 0, 0, K_MIS, 4'h0, 32'h0, 32'h0, 0));
        tbl.push_back(mk(1, 0, 3'b010, 32'h4000, 32'h0, 32'h11112222, 1, 1, K_BUS, 4'hF, 32'h0, 32'h0, 1));
        tbl.push_back(mk(1, 1, 3'b010, 32'h4000, 32'h0, 32'h0, 0, 0, K_FAULT, 4'h0, 32'h0, 32'h0, 1));
        tbl.push_back(mk(1, 0, 3'b001, 32'h5002, 32'h0, 32'h9ABC1234, 0, 0, K_BUS, 4'hF, 32'h0, 32'hFFFF9ABC, 0));
        tbl.push_back(mk(1, 0, 3'b101, 32'h5000, 32'h0, 32'h9ABC8001, 0, 0, K_BUS, 4'hF, 32'h0, 32'h00008001, 0));
        tbl.push_back(mk(0, 1, 3'b000, 32'h6001, 32'h000000A5, 32'h0, 0, 1, K_BUS, 4'b0010, 32'hA5A5A5A5, 32'h00008001, 0));
        tbl.push_back(mk(0, 1, 3'b010, 32'h7000, 32'h12345678, 32'h0, 0, 2, K_BUS, 4'hF, 32'h12345678, 32'h00008001, 0));
        tbl.push_back(mk(1, 0, 3'b010, 32'h8000, 32'h0, 32'hCAFEF00D, 0, 0, K_BUS, 4'hF, 32'h0, 32'hCAFEF00D, 0));
        tbl.push_back(mk(1, 0, 3'b011, 32'h8000, 32'h0, 32'h0, 0, 0, K_FAULT, 4'h0, 32'h0, 32'hCAFEF00D, 1));
        tbl.push_back(mk(0, 1, 3'b100, 32'h8000, 32'h1, 32'h0, 0, 0, K_FAULT, 4'h0, 32'h0, 32'hCAFEF00D, 1));
        tbl.push_back(mk(0, 1, 3'b001, 32'h9001, 32'h1, 32'h0, 0, 0, K_MIS, 4'h0, 32'h0, 32'h0, 0));
        tbl.push_back(mk(1, 0, 3'b000, 32'h9000, 32'h0, 32'h0000007F, 0, 0, K_BUS, 4'hF, 32'h0, 32'h0000007F, 0));
        tbl.push_back(mk(1, 0, 3'b001, 32'hA001, 32'h0, 32'h0, 0, 0, K_MIS, 4'h0, 32'h0, 32'h0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            run_op($sformatf("vec%0d", i), tbl[i]);
        end
        model_rd = 32'h0;

        // A stray acknowledge while idle must change nothing.
        @(negedge CLK);
        BusAck = 1'b1; BusErr = 1'b1; BusRData = 32'h12345678;
        #1;
        chk("stray ack stall", 32'(StallM), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        BusAck = 1'b0; BusErr = 1'b0;
        #1;
        chk("stray ack busreq", 32'(BusReq), 32'd0);
        chk("stray ack fault", 32'(AccessFaultM), 32'd0);
        chk("stray ack readdata", ReadDataM, model_rd);

        // Reset pulled during the second REQ cycle of a store.
        @(negedge CLK);
        MemWriteM = 1'b1; Funct3M = 3'b001; AddrM = 32'h2002; WriteDataM = 32'hDEADBEEF;
        @(posedge CLK);
        @(negedge CLK);
        #1;
        chk("rst req1 busreq", 32'(BusReq), 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        RESETn = 1'b0;
        #1;
        chk("rst busreq drop", 32'(BusReq), 32'd0);
        chk("rst be clear", 32'(BusByteEn), 32'd0);
        chk("rst flags", 32'({MisalignM, AccessFaultM}), 32'd0);
        idle_inputs();
        @(negedge CLK);
        RESETn = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        #1;
        chk("rst after release", 32'({BusReq, AccessFaultM, StallM}), 32'd0);
        run_op("reissue", mk(0, 1, 3'b001, 32'h2002, 32'hDEADBEEF, 32'h0, 0, 1, K_BUS, 4'b1100, 32'hBEEFBEEF, 32'h0, 0));
        model_rd = 32'h0;

        // Randomized accesses against the reference model.
        for (int n = 0; n < 60; n++) begin
            sel  = int'($urandom_range(0, 19));
            r_rd = (sel < 9) || (sel == 19);
            r_wr = (sel >= 9);
            v = model(r_rd, r_wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                      ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)), model_rd);
            run_op($sformatf("rand%0d", n), v);
            model_rd = v.exp_rd;
        end

`ifdef LSU_TIMEOUT_EN
        v = mk(1, 0, 3'b010, 32'h0000B000, 32'h0, 32'h5555AAAA, 0, -1, K_BUS, 4'hF, 32'h0, 32'h0, 1);
        run_op("timeout", v);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit, directly upstream of the MEM/WB pipeline register.
- Takes the M-stage access request: control, Funct3M, address = ComputeResultM, and store data.
- Runs a request/acknowledge transaction on the data bus, with byte-lane alignment for stores and sign/zero extension for loads.
- Produces ReadDataM for the MEM/WB register and holds the pipeline through StallM until the access completes.

Parameters:
- TIMEOUT_CYCLES, 255: number of REQ cycles without BusAck before the access is aborted. Used only with LSU_TIMEOUT_EN.
- CNT_W, 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESETn  in  1  reset, asynchronous, active-low.
- MemReadM  in  1  M-stage load.
- MemWriteM  in  1  M-stage store.
- Funct3M  in  3  access size and signedness, per RV32I load/store encoding.
- AddrM  in  32  effective address (ComputeResultM).
- WriteDataM  in  32  store source register value.
- ReadDataM  out  32  extended load result for the MEM/WB register.
- StallM  out  1  hold F/D/E/M stages this cycle.
- MisalignM  out  1  one-cycle misaligned-access flag.
- AccessFaultM  out  1  one-cycle fault flag: illegal funct3, read and write both set, bus error, or timeout.
- BusReq  out  1  bus request.
- BusWe  out  1  1 = write.
- BusAddr  out  32  word-aligned address, {addr[31:2], 2'b00}.
- BusByteEn  out  4  byte-lane enables.
- BusWData  out  32  lane-replicated store data.
- BusAck  in  1  transaction complete, single-cycle pulse.
- BusErr  in  1  valid only with BusAck.
- BusRData  in  32  read data, valid with BusAck.

Behaviour:
- FSM states: IDLE, REQ, DONE. Reset (RESETn=0, asynchronous) forces:
  - state IDLE
  - BusReq=0, BusWe=0, BusAddr=0, BusByteEn=0, BusWData=0
  - ReadDataM=0, MisalignM=0, AccessFaultM=0, timeout counter 0
- StallM is combinational: 1 in REQ; 1 in IDLE when a legal, aligned access is present; otherwise 0.
- IDLE, no access (MemReadM=MemWriteM=0): stay in IDLE, ReadDataM holds its previous value.
- IDLE, MemReadM=MemWriteM=1: AccessFaultM=1 the next cycle, no bus activity, StallM=0.
- IDLE, illegal funct3 (loads 011/110/111; stores other than 000/001/010): same as above, AccessFaultM=1, no bus activity.
- IDLE, misaligned access (half with addr[0]=1; word with addr[1:0]!=0): MisalignM=1 the next cycle, ReadDataM=0, no bus activity, StallM=0.
- IDLE, legal access: register the bus outputs and latch funct3 and addr[1:0], then go to REQ.
  - BusReq asserts in the first REQ cycle.
  - Store lanes: SB BusByteEn=4'b0001<<a, BusWData={4{wd[7:0]}}. SH 4'b0011<<a, {2{wd[15:0]}}. SW 4'b1111, wd.
  - Load: BusByteEn=4'b1111, BusWe=0.
- REQ: BusReq and all bus outputs stay stable until BusAck. On the BusAck cycle:
  - Drop BusReq the next cycle and go to DONE.
  - Load: ReadDataM <= extract(BusRData>>(8*a)). LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - BusErr=1: ReadDataM <= 0 and AccessFaultM=1 during DONE.
- DONE: StallM=0 for exactly one cycle so the instruction advances; always return to IDLE. DONE never starts a new access.
- Latency: 1 + N + 1 cycles, where N is the number of REQ cycles including the ack cycle. Minimum is 3 cycles.
- A BusAck that arrives in IDLE or DONE is ignored.
- MisalignM and AccessFaultM are never asserted together.
- Reset asserted mid-transaction: BusReq drops immediately; no completion flag is produced.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined: the counter clears on entry to REQ and increments every REQ cycle without BusAck. When it reaches TIMEOUT_CYCLES, BusReq drops, the FSM goes to DONE, ReadDataM <= 0, and AccessFaultM=1 in DONE.
- Not defined: no counter is built and REQ waits for BusAck indefinitely.

Test Plan:
- LB at AddrM=0x1003, BusRData=0x80_12_34_56, ack on the 1st REQ cycle -> BusByteEn=1111, BusAddr=0x1000, ReadDataM=0xFFFFFF80 in DONE, StallM high for 2 cycles. LBU at the same address -> 0x00000080.
- SH at AddrM=0x2002 with WriteDataM=0xDEADBEEF -> BusWe=1, BusByteEn=1100, BusWData=0xBEEFBEEF, outputs stable for 3 wait cycles until ack.
- LW at AddrM=0x3001 -> MisalignM=1 for one cycle, BusReq never rises, StallM=0, ReadDataM=0.
- LW with ack+BusErr=1 -> ReadDataM=0, AccessFaultM=1 in DONE. MemReadM=MemWriteM=1 -> AccessFaultM=1, no bus activity.
- RESETn low during the 2nd REQ cycle of a store -> BusReq=0 immediately, state IDLE; the access re-issues cleanly after release.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> BusReq high for exactly 4 cycles, then AccessFaultM=1 and StallM=0 in DONE.
